// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
//
// Edit controller for a 24-hour BCD clock with one alarm. A set request seeds
// an edit buffer (from the running time or from the stored alarm). The user
// then steps the hour field, then the minute field, and finally commits. A
// commit emits a one-cycle load strobe toward the clock, or updates the
// internal alarm register. Cancel, or a period with no activity, drops the
// edit without loading anything.
//
// Parameters
//   TIMEOUT_CYC : idle cycles allowed in an edit state before auto-abort
//   BLINK_CYC   : cycles per half-period of the blink output
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous, active-low
//   set_time_p / set_alarm_p start editing the time / the alarm (IDLE only)
//   inc_p, next_p, cancel_p  edit controls; cancel > next > inc
//   cur_h1..cur_m0           running clock time, BCD
//   H1, H0, M1, M0           edit buffer, BCD, to the clock load inputs
//   load_time, load_alarm    one-cycle commit strobes
//   editing, edit_hours      edit status
//   blink                    display blink enable while editing
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int BLINK_CYC   = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_time_p,
    input  logic       set_alarm_p,
    input  logic       inc_p,
    input  logic       next_p,
    input  logic       cancel_p,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [2:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] H1,
    output logic [3:0] H0,
    output logic [2:0] M1,
    output logic [3:0] M0,
    output logic       load_time,
    output logic       load_alarm,
    output logic       editing,
    output logic       edit_hours,
    output logic       blink
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDIT_H,
        S_EDIT_M,
        S_COMMIT
    } state_t;

    state_t          state_q;
    logic            target_q;      // 0 = time, 1 = alarm
    logic [1:0]      edt_h1_q;
    logic [3:0]      edt_h0_q;
    logic [2:0]      edt_m1_q;
    logic [3:0]      edt_m0_q;
    logic [1:0]      alm_h1_q;
    logic [3:0]      alm_h0_q;
    logic [2:0]      alm_m1_q;
    logic [3:0]      alm_m0_q;
    logic [TW-1:0]   tmo_q;
    logic [BW-1:0]   blink_cnt_q;
    logic            blink_q;
    logic            editing_q;
    logic            edit_hours_q;
    logic            load_time_q;
    logic            load_alarm_q;

    // Seed source, validated seed, BCD increments and abort decision
    logic [1:0] src_h1;
    logic [3:0] src_h0;
    logic [2:0] src_m1;
    logic [3:0] src_m0;
    logic       hour_ok;
    logic       min_ok;
    logic [1:0] seed_h1_d;
    logic [3:0] seed_h0_d;
    logic [2:0] seed_m1_d;
    logic [3:0] seed_m0_d;
    logic [1:0] inc_h1_d;
    logic [3:0] inc_h0_d;
    logic [2:0] inc_m1_d;
    logic [3:0] inc_m0_d;
    logic       abort_d;
    logic       blink_wrap;

    always_comb begin
        // set_time_p has priority when both requests arrive together
        src_h1 = set_time_p ? cur_h1 : alm_h1_q;
        src_h0 = set_time_p ? cur_h0 : alm_h0_q;
        src_m1 = set_time_p ? cur_m1 : alm_m1_q;
        src_m0 = set_time_p ? cur_m0 : alm_m0_q;

        // Hour valid for 00..19 and 20..23; a tens digit of 3 is never valid
        hour_ok = ((src_h1 < 2'd2) && (src_h0 <= 4'd9)) ||
                  ((src_h1 == 2'd2) && (src_h0 <= 4'd3));
        min_ok  = (src_m1 <= 3'd5) && (src_m0 <= 4'd9);

        seed_h1_d = hour_ok ? src_h1 : 2'd0;
        seed_h0_d = hour_ok ? src_h0 : 4'd0;
        seed_m1_d = min_ok  ? src_m1 : 3'd0;
        seed_m0_d = min_ok  ? src_m0 : 4'd0;

        // The buffer always holds a valid time, so only the wrap points matter
        inc_h1_d = edt_h1_q;
        inc_h0_d = edt_h0_q + 4'd1;
        if ((edt_h1_q == 2'd2) && (edt_h0_q == 4'd3)) begin
            inc_h1_d = 2'd0;
            inc_h0_d = 4'd0;
        end else if (edt_h0_q == 4'd9) begin
            inc_h1_d = edt_h1_q + 2'd1;
            inc_h0_d = 4'd0;
        end

        inc_m1_d = edt_m1_q;
        inc_m0_d = edt_m0_q + 4'd1;
        if (edt_m0_q == 4'd9) begin
            inc_m0_d = 4'd0;
            inc_m1_d = (edt_m1_q == 3'd5) ? 3'd0 : edt_m1_q + 3'd1;
        end

        // An accepted next/inc in the last idle cycle keeps the edit alive
        abort_d    = cancel_p || ((tmo_q == TMO_LAST) && !next_p && !inc_p);
        blink_wrap = (blink_cnt_q == BLINK_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            target_q     <= 1'b0;
            edt_h1_q     <= '0;
            edt_h0_q     <= '0;
            edt_m1_q     <= '0;
            edt_m0_q     <= '0;
            alm_h1_q     <= '0;
            alm_h0_q     <= '0;
            alm_m1_q     <= '0;
            alm_m0_q     <= '0;
            tmo_q        <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            editing_q    <= 1'b0;
            edit_hours_q <= 1'b0;
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
        end else begin
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (set_time_p || set_alarm_p) begin
                        state_q      <= S_EDIT_H;
                        target_q     <= ~set_time_p;
                        edt_h1_q     <= seed_h1_d;
                        edt_h0_q     <= seed_h0_d;
                        edt_m1_q     <= seed_m1_d;
                        edt_m0_q     <= seed_m0_d;
                        tmo_q        <= '0;
                        blink_cnt_q  <= '0;
                        blink_q      <= 1'b1;
                        editing_q    <= 1'b1;
                        edit_hours_q <= 1'b1;
                    end
                end
                S_EDIT_H, S_EDIT_M: begin
                    if (abort_d) begin
                        state_q      <= S_IDLE;
                        tmo_q        <= '0;
                        blink_cnt_q  <= '0;
                        blink_q      <= 1'b0;
                        editing_q    <= 1'b0;
                        edit_hours_q <= 1'b0;
                    end else if (next_p) begin
                        tmo_q <= '0;
                        if (state_q == S_EDIT_H) begin
                            // Blink phase continues across the field change
                            state_q      <= S_EDIT_M;
                            edit_hours_q <= 1'b0;
                            blink_cnt_q  <= blink_wrap ? '0 : blink_cnt_q + BW'(1);
                            blink_q      <= blink_q ^ blink_wrap;
                        end else begin
                            state_q      <= S_COMMIT;
                            editing_q    <= 1'b0;
                            blink_cnt_q  <= '0;
                            blink_q      <= 1'b0;
                            load_time_q  <= ~target_q;
                            load_alarm_q <= target_q;
                        end
                    end else begin
                        blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BW'(1);
                        blink_q     <= blink_q ^ blink_wrap;
                        if (inc_p) begin
                            tmo_q <= '0;
                            if (state_q == S_EDIT_H) begin
                                edt_h1_q <= inc_h1_d;
                                edt_h0_q <= inc_h0_d;
                            end else begin
                                edt_m1_q <= inc_m1_d;
                                edt_m0_q <= inc_m0_d;
                            end
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    if (target_q) begin
                        alm_h1_q <= edt_h1_q;
                        alm_h0_q <= edt_h0_q;
                        alm_m1_q <= edt_m1_q;
                        alm_m0_q <= edt_m0_q;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign H1         = edt_h1_q;
    assign H0         = edt_h0_q;
    assign M1         = edt_m1_q;
    assign M0         = edt_m0_q;
    assign load_time  = load_time_q;
    assign load_alarm = load_alarm_q;
    assign editing    = editing_q;
    assign edit_hours = edit_hours_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Self-checking bench for clock_set_ctrl: a table of directed vectors, a few
// hand-written multi-cycle sequences (timeout, blink, reset) and a randomized
// run. An integer-level reference model predicts every output every cycle.
// ---------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int T = 20;   // TIMEOUT_CYC used for this bench
    localparam int B = 4;    // BLINK_CYC used for this bench

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_ST   = 5'b10000;
    localparam logic [4:0] P_SA   = 5'b01000;
    localparam logic [4:0] P_INC  = 5'b00100;
    localparam logic [4:0] P_NX   = 5'b00010;
    localparam logic [4:0] P_CN   = 5'b00001;

    // flags: {load_time, load_alarm, editing}
    localparam logic [2:0] F_0  = 3'b000;
    localparam logic [2:0] F_ED = 3'b001;
    localparam logic [2:0] F_LA = 3'b010;
    localparam logic [2:0] F_LT = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic       set_time_p, set_alarm_p, inc_p, next_p, cancel_p;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0;
    logic [2:0] cur_m1;
    logic [3:0] cur_m0;
    logic [1:0] H1;
    logic [3:0] H0;
    logic [2:0] M1;
    logic [3:0] M0;
    logic       load_time, load_alarm, editing, edit_hours, blink;
    logic [17:0] dut_out;

    int total;
    int bad;

    // Reference model state: plain integers, not the DUT encoding
    int m_mode;     // 0 idle, 1 hours, 2 minutes, 3 commit
    int m_tgt;      // 0 time, 1 alarm
    int m_hour, m_min;
    int a_hour, a_min;
    int m_idle;     // idle cycles since last activity
    int m_age;      // cycles since edit entry

    typedef struct {
        logic [4:0]  pulses;
        int          rep;
        logic [12:0] cur;
        int          hh;
        int          mm;
        logic [2:0]  flags;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] cA, cB, cC, cD, cE, cF, cG;
    logic        quiet;

    clock_set_ctrl #(
        .TIMEOUT_CYC(T),
        .BLINK_CYC  (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .set_time_p (set_time_p),
        .set_alarm_p(set_alarm_p),
        .inc_p      (inc_p),
        .next_p     (next_p),
        .cancel_p   (cancel_p),
        .cur_h1     (cur_h1),
        .cur_h0     (cur_h0),
        .cur_m1     (cur_m1),
        .cur_m0     (cur_m0),
        .H1         (H1),
        .H0         (H0),
        .M1         (M1),
        .M0         (M0),
        .load_time  (load_time),
        .load_alarm (load_alarm),
        .editing    (editing),
        .edit_hours (edit_hours),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    assign dut_out = {H1, H0, M1, M0, load_time, load_alarm, editing, edit_hours, blink};

    function automatic logic [12:0] bcd(input int hh, input int mm);
        logic [1:0] a;
        logic [3:0] b;
        logic [2:0] c;
        logic [3:0] d;
        a = 2'(hh / 10);
        b = 4'(hh % 10);
        c = 3'(mm / 10);
        d = 4'(mm % 10);
        return {a, b, c, d};
    endfunction

    function automatic vec_t mk(input logic [4:0] p, input int rep, input logic [12:0] cur,
                                input int hh, input int mm, input logic [2:0] fl);
        vec_t v;
        v.pulses = p;
        v.rep    = rep;
        v.cur    = cur;
        v.hh     = hh;
        v.mm     = mm;
        v.flags  = fl;
        return v;
    endfunction

    function automatic logic [17:0] model_out();
        logic ed;
        logic bl;
        ed = (m_mode == 1) || (m_mode == 2);
        bl = ed && (((m_age / B) % 2) == 0);
        return {bcd(m_hour, m_min),
                (m_mode == 3) && (m_tgt == 0),
                (m_mode == 3) && (m_tgt == 1),
                ed, (m_mode == 1), bl};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_tgt = 0;
        m_hour = 0; m_min = 0;
        a_hour = 0; a_min = 0;
        m_idle = 0; m_age = 0;
    endtask

    task automatic model_step();
        int hh;
        int mm;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                if (set_time_p || set_alarm_p) begin
                    m_tgt = set_time_p ? 0 : 1;
                    if (set_time_p) begin
                        hh = int'(cur_h1) * 10 + int'(cur_h0);
                        mm = int'(cur_m1) * 10 + int'(cur_m0);
                        m_hour = (cur_h0 > 4'd9 || hh > 23) ? 0 : hh;
                        m_min  = (cur_m0 > 4'd9 || mm > 59) ? 0 : mm;
                    end else begin
                        m_hour = a_hour;
                        m_min  = a_min;
                    end
                    m_mode = 1; m_idle = 0; m_age = 0;
                end
            end
            1, 2: begin
                if (cancel_p) m_mode = 0;
                else if (next_p) begin
                    m_mode = (m_mode == 1) ? 2 : 3;
                    m_idle = 0; m_age++;
                end else if (inc_p) begin
                    if (m_mode == 1) m_hour = (m_hour + 1) % 24;
                    else             m_min  = (m_min + 1) % 60;
                    m_idle = 0; m_age++;
                end else if (m_idle == T - 1) m_mode = 0;
                else begin
                    m_idle++; m_age++;
                end
            end
            default: begin
                if (m_tgt == 1) begin
                    a_hour = m_hour;
                    a_min  = m_min;
                end
                m_mode = 0;
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic set_pulses(input logic [4:0] p);
        {set_time_p, set_alarm_p, inc_p, next_p, cancel_p} = p;
    endtask

    // One clock: model follows the edge, outputs compared 1ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cycle", 32'(dut_out), 32'(model_out()));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        set_pulses(P_NONE);
        {cur_h1, cur_h0, cur_m1, cur_m0} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(dut_out), 32'd0);
        reset = 1'b1;

        cA = {2'd2, 4'd2, 3'd4, 4'd8};    // 22:48
        cB = {2'd1, 4'd0, 3'd1, 4'd0};    // 10:10
        cC = {2'd1, 4'd2, 3'd3, 4'd4};    // 12:34
        cD = {2'd2, 4'd7, 3'd6, 4'd3};    // 27:63
        cE = {2'd1, 4'd10, 3'd5, 4'd12};  // non-BCD digits
        cF = {2'd1, 4'd9, 3'd0, 4'd9};    // 19:09
        cG = {2'd2, 4'd3, 3'd5, 4'd9};    // 23:59

        // time set: 22:48 -> 00:00
        vecs.push_back(mk(P_ST,   1, cA, 22, 48, F_ED));
        vecs.push_back(mk(P_INC,  2, cA,  0, 48, F_ED));
        vecs.push_back(mk(P_NX,   1, cA,  0, 48, F_ED));
        vecs.push_back(mk(P_INC, 12, cA,  0,  0, F_ED));
        vecs.push_back(mk(P_NX,   1, cA,  0,  0, F_LT));
        vecs.push_back(mk(P_NONE, 1, cA,  0,  0, F_0));
        // alarm set to 03:05, then reseed from the alarm register
        vecs.push_back(mk(P_SA,   1, cA,  0,  0, F_ED));
        vecs.push_back(mk(P_INC,  3, cA,  3,  0, F_ED));
        vecs.push_back(mk(P_NX,   1, cA,  3,  0, F_ED));
        vecs.push_back(mk(P_INC,  5, cA,  3,  5, F_ED));
        vecs.push_back(mk(P_NX,   1, cA,  3,  5, F_LA));
        vecs.push_back(mk(P_NONE, 1, cA,  3,  5, F_0));
        vecs.push_back(mk(P_ST,   1, cB, 10, 10, F_ED));
        vecs.push_back(mk(P_CN,   1, cB, 10, 10, F_0));
        vecs.push_back(mk(P_SA,   1, cB,  3,  5, F_ED));
        vecs.push_back(mk(P_ST,   1, cB,  3,  5, F_ED));   // ignored while editing
        // priority in EDIT_M
        vecs.push_back(mk(P_NX,   1, cB,  3,  5, F_ED));
        vecs.push_back(mk(P_NX | P_INC, 1, cB, 3, 5, F_LA));
        vecs.push_back(mk(P_NONE, 1, cB,  3,  5, F_0));
        vecs.push_back(mk(P_ST,   1, cB, 10, 10, F_ED));
        vecs.push_back(mk(P_NX,   1, cB, 10, 10, F_ED));
        vecs.push_back(mk(P_CN | P_NX, 1, cB, 10, 10, F_0));
        // both set requests together: time wins
        vecs.push_back(mk(P_ST | P_SA, 1, cC, 12, 34, F_ED));
        vecs.push_back(mk(P_NX,   2, cC, 12, 34, F_LT));
        vecs.push_back(mk(P_NONE, 1, cC, 12, 34, F_0));
        // invalid seeds
        vecs.push_back(mk(P_ST,   1, cD,  0,  0, F_ED));
        vecs.push_back(mk(P_CN,   1, cD,  0,  0, F_0));
        vecs.push_back(mk(P_ST,   1, cE,  0,  0, F_ED));
        vecs.push_back(mk(P_CN,   1, cE,  0,  0, F_0));
        // BCD step boundaries
        vecs.push_back(mk(P_ST,   1, cF, 19,  9, F_ED));
        vecs.push_back(mk(P_INC,  1, cF, 20,  9, F_ED));
        vecs.push_back(mk(P_NX,   1, cF, 20,  9, F_ED));
        vecs.push_back(mk(P_INC,  1, cF, 20, 10, F_ED));
        vecs.push_back(mk(P_CN,   1, cF, 20, 10, F_0));
        vecs.push_back(mk(P_ST,   1, cG, 23, 59, F_ED));
        vecs.push_back(mk(P_INC,  1, cG,  0, 59, F_ED));
        vecs.push_back(mk(P_NX,   1, cG,  0, 59, F_ED));
        vecs.push_back(mk(P_INC,  1, cG,  0,  0, F_ED));
        vecs.push_back(mk(P_CN,   1, cG,  0,  0, F_0));

        foreach (vecs[i]) begin
            set_pulses(vecs[i].pulses);
            {cur_h1, cur_h0, cur_m1, cur_m0} = vecs[i].cur;
            for (int r = 0; r < vecs[i].rep; r++) tick();
            set_pulses(P_NONE);
            chk($sformatf("vec%0d", i),
                32'({H1, H0, M1, M0, load_time, load_alarm, editing}),
                32'({bcd(vecs[i].hh, vecs[i].mm), vecs[i].flags}));
        end

        // timeout with no activity
        set_time_p = 1'b1; tick(); set_time_p = 1'b0;
        repeat (T - 1) tick();
        chk("tmo_hold", 32'(editing), 32'd1);
        tick();
        chk("tmo_abort", 32'({editing, load_time, load_alarm}), 32'd0);

        // inc_p at idle count T-2 restarts the window
        set_time_p = 1'b1; tick(); set_time_p = 1'b0;
        repeat (T - 2) tick();
        inc_p = 1'b1; tick(); inc_p = 1'b0;
        repeat (T - 1) tick();
        chk("tmo_ext_hold", 32'(editing), 32'd1);
        tick();
        chk("tmo_ext_abort", 32'(editing), 32'd0);

        // inc_p in the very last idle cycle wins over the timeout (23 -> 00)
        set_time_p = 1'b1; tick(); set_time_p = 1'b0;
        repeat (T - 1) tick();
        inc_p = 1'b1; tick(); inc_p = 1'b0;
        chk("tmo_inc_wins", 32'({editing, H1, H0}), 32'({1'b1, 2'd0, 4'd0}));
        cancel_p = 1'b1; tick(); cancel_p = 1'b0;

        // blink waveform
        set_alarm_p = 1'b1; tick(); set_alarm_p = 1'b0;
        chk("blink_entry", 32'(blink), 32'd1);
        repeat (B - 1) tick();
        chk("blink_first_half", 32'(blink), 32'd1);
        tick();
        chk("blink_toggle", 32'(blink), 32'd0);
        repeat (B) tick();
        chk("blink_back", 32'(blink), 32'd1);
        cancel_p = 1'b1; tick(); cancel_p = 1'b0;
        chk("blink_idle", 32'(blink), 32'd0);

        // asynchronous reset in EDIT_M clears outputs and the alarm register
        set_alarm_p = 1'b1; tick(); set_alarm_p = 1'b0;
        next_p = 1'b1; tick(); next_p = 1'b0;
        chk("pre_rst_seed", 32'({H1, H0, M1, M0}), 32'(bcd(3, 5)));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_async", 32'(dut_out), 32'd0);
        repeat (2) tick();
        chk("rst_no_strobe", 32'({load_time, load_alarm}), 32'd0);
        reset = 1'b1;
        set_alarm_p = 1'b1; tick(); set_alarm_p = 1'b0;
        chk("rst_alarm_cleared", 32'({editing, H1, H0, M1, M0}), 32'({1'b1, 13'd0}));
        cancel_p = 1'b1; tick(); cancel_p = 1'b0;

        // randomized run, alternating busy and quiet phases
        for (int c = 0; c < 3000; c++) begin
            quiet = (((c / 300) % 2) == 1);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    {cur_h1, cur_h0, cur_m1, cur_m0} = 13'($urandom);
                else
                    {cur_h1, cur_h0, cur_m1, cur_m0} =
                        bcd(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
            end
            if (quiet) begin
                set_time_p  = ($urandom_range(0, 63) == 0);
                set_alarm_p = ($urandom_range(0, 63) == 0);
                inc_p       = ($urandom_range(0, 63) == 0);
                next_p      = ($urandom_range(0, 63) == 0);
                cancel_p    = ($urandom_range(0, 63) == 0);
            end else begin
                set_time_p  = ($urandom_range(0, 7) == 0);
                set_alarm_p = ($urandom_range(0, 7) == 0);
                inc_p       = ($urandom_range(0, 3) == 0);
                next_p      = ($urandom_range(0, 9) == 0);
                cancel_p    = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            tick();
        end
        set_pulses(P_NONE);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000, meaning idle cycles in an edit state before auto-abort.
REQ-002 SHALL have parameter BLINK_CYC, default 250, meaning cycles per half-period of the blink output.
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port set_time_p  in  1  one-cycle pulse, request to edit current time.
REQ-006 SHALL have port set_alarm_p  in  1  one-cycle pulse, request to edit alarm time.
REQ-007 SHALL have port inc_p  in  1  one-cycle pulse, increment the field being edited.
REQ-008 SHALL have port next_p  in  1  one-cycle pulse, advance to the next field or commit.
REQ-009 SHALL have port cancel_p  in  1  one-cycle pulse, abort the edit without loading.
REQ-010 SHALL have ports cur_h1/cur_h0/cur_m1/cur_m0  in  2/4/3/4  running clock time (BCD).
REQ-011 SHALL have ports H1/H0/M1/M0  out  2/4/3/4  edit buffer (BCD), driven to the clock's load inputs.
REQ-012 SHALL have ports load_time, load_alarm  out  1 each  one-cycle load strobes.
REQ-013 SHALL have port editing  out  1  high in any edit state.
REQ-014 SHALL have port edit_hours  out  1  high in EDIT_H only.
REQ-015 SHALL have port blink  out  1  display blink enable.

Function
REQ-016 SHALL implement FSM states IDLE, EDIT_H, EDIT_M, COMMIT, plus a 1-bit target register (0 = time, 1 = alarm).
REQ-017 IDLE, set_time_p: SHALL go to EDIT_H with target = 0 and seed the buffer from cur_*.
REQ-018 IDLE, set_alarm_p: SHALL go to EDIT_H with target = 1 and seed the buffer from the internal alarm register.
REQ-019 IDLE, both pulses in the same cycle: set_time_p SHALL win.
REQ-020 Seeding: if the seeded hour > 23 or contains a non-BCD digit, the hour field SHALL seed 00; likewise a minute > 59 SHALL seed 00.
REQ-021 In edit states, set_time_p and set_alarm_p SHALL be ignored.
REQ-022 Edit-state priority per cycle SHALL be cancel_p > next_p > inc_p; only the highest-priority pulse acts.
REQ-023 inc_p in EDIT_H: hour SHALL step BCD 00..23; 09->10, 19->20, 23->00.
REQ-024 inc_p in EDIT_M: minute SHALL step BCD 00..59; 09->10, 59->00, with no carry into the hour.
REQ-025 next_p: EDIT_H SHALL go to EDIT_M; EDIT_M SHALL go to COMMIT.
REQ-026 COMMIT SHALL last exactly one cycle, asserting load_time (target 0) or load_alarm (target 1), then return to IDLE.
REQ-027 On an alarm commit, the alarm register SHALL capture the buffer in the COMMIT cycle.
REQ-028 cancel_p in EDIT_H/EDIT_M: SHALL go to IDLE next cycle, with no strobe and the alarm register unchanged.
REQ-029 Timeout counter: SHALL clear on state entry and on any accepted inc_p or next_p, and otherwise increment in EDIT_H/EDIT_M.
REQ-030 Timeout: reaching TIMEOUT_CYC-1 SHALL abort to IDLE exactly as cancel does; an accepted pulse in that same cycle wins.
REQ-031 Buffer outputs SHALL hold their last value in IDLE; they are stable during the COMMIT cycle.
REQ-032 load_time and load_alarm SHALL be registered, mutually exclusive, and never high outside COMMIT.
REQ-033 Blink counter: SHALL run only in edit states and toggle blink every BLINK_CYC cycles; blink SHALL be 0 in IDLE/COMMIT and start at 1 on edit entry.
REQ-034 edit_hours SHALL be 1 only in EDIT_H; editing SHALL be 1 in EDIT_H and EDIT_M.

Reset
REQ-035 reset low SHALL immediately force state IDLE and target 0.
REQ-036 reset low SHALL also zero the buffer, alarm register, counters and all outputs.
REQ-037 reset asserted mid-edit or in COMMIT SHALL produce no strobe.
REQ-038 After reset deassertion, the block SHALL accept a pulse on the first clock edge.

Verification
REQ-039 Time set: cur = 22:48, set_time_p, inc_p x2, next_p, inc_p x12, next_p -> one-cycle load_time with H1..M0 = 00:00; load_alarm stays 0.
REQ-040 Alarm set and reseed: set_alarm_p, 3x inc_p (00->03), next_p, 5x inc_p (00->05), next_p -> load_alarm with 03:05; a second set_alarm_p seeds 03:05.
REQ-041 Priority: in EDIT_M, next_p and inc_p together -> COMMIT with the minute unchanged; cancel_p and next_p together -> IDLE, no strobe.
REQ-042 Timeout: enter EDIT_H and apply no pulses -> IDLE after TIMEOUT_CYC cycles, no strobe; an inc_p at cycle TIMEOUT_CYC-2 extends the window.
REQ-043 Invalid seed: cur = 2,7,6,3 (27:63) -> buffer seeds 00:00.
REQ-044 Reset: reset low during EDIT_M -> outputs 0 in the same cycle, no load strobe, and the alarm register returns to 00:00.
